vector3_unpacker: RTL

Byte-serial receiver that reassembles the 32-bit packed word produced by the Vector3 packing block. That word is {a, b, c, d, e, f, 2'b11}, transmitted as four bytes w, x, y, z, most significant byte first. The block collects the four bytes over a valid/ready stream, splits the word back into six 5-bit fields, checks the 2-bit trailer and presents the fields on a registered valid/ready output. It sits at the consuming end of the byte link that carries Vector3 output.

---
 rtl/vector3_unpacker.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/vector3_unpacker.sv
// vector3_unpacker
// Byte-serial receiver for the Vector3 packed word {a, b, c, d, e, f, 2'b11}.
// The four bytes arrive MSB first. They are reassembled, split into six 5-bit
// fields, and presented on a registered valid/ready output.
//
// Ports
//   clk        sole clock, rising edge
//   rst        synchronous active-high reset
//   sync       resynchronise: drop any partial word, next accepted byte is byte 0
//   in_data    incoming byte (w first, z last)
//   in_valid   in_data valid
//   in_ready   byte accepted this cycle (combinational on out_ready when cnt==3)
//   a..f       unpacked 5-bit fields (registered)
//   err        trailer of presented word != 2'b11 (registered)
//   out_valid  fields/err valid
//   out_ready  consumer accepts fields
//
// Build option
//   VECTOR3_UNPACKER_CHECK_EN  defined: trailer checked into err
//                              undefined: err tied to 0, trailer ignored

module vector3_unpacker (
  input  logic       clk,
  input  logic       rst,
  input  logic       sync,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [4:0] a,
  output logic [4:0] b,
  output logic [4:0] c,
  output logic [4:0] d,
  output logic [4:0] e,
  output logic [4:0] f,
  output logic       err,
  output logic       out_valid,
  input  logic       out_ready
);

  localparam int unsigned FIELD_W = 5;
  localparam int unsigned HOLD_W  = 24;
  localparam int unsigned CNT_W   = 2;

  localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(3);

  typedef struct packed {
    logic [FIELD_W-1:0] a;
    logic [FIELD_W-1:0] b;
    logic [FIELD_W-1:0] c;
    logic [FIELD_W-1:0] d;
    logic [FIELD_W-1:0] e;
    logic [FIELD_W-1:0] f;
  } fields_t;

  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  fields_t           fields_q, fields_d;
  logic              valid_q, valid_d;

  logic              in_xfer;
  logic              out_xfer;
  logic              word_done;
  logic [CNT_W-1:0]  pos;

  // Byte 3 may only stall while a presented word is not draining.
  assign in_ready  = (cnt_q != LAST_BYTE) || !valid_q || out_ready;
  assign in_xfer   = in_valid && in_ready;
  assign out_xfer  = valid_q && out_ready;

  // sync makes the byte of this cycle byte 0, so it can never complete a word.
  assign pos       = sync ? '0 : cnt_q;
  assign word_done = in_xfer && (pos == LAST_BYTE);

  // Next-state logic for counter, holding register and output register.
  always_comb begin
    cnt_d    = cnt_q;
    hold_d   = hold_q;
    fields_d = fields_q;
    valid_d  = valid_q;

    if (sync) begin
      cnt_d = in_xfer ? CNT_W'(1) : '0;
    end else if (in_xfer) begin
      cnt_d = cnt_q + CNT_W'(1);
    end

    if (in_xfer && !word_done) begin
      case (pos)
        CNT_W'(0): hold_d[23:16] = in_data;
        CNT_W'(1): hold_d[15:8]  = in_data;
        CNT_W'(2): hold_d[7:0]   = in_data;
        default:   hold_d        = hold_q;
      endcase
    end

    // A reload in the same cycle as a drain keeps out_valid high.
    if (word_done) begin
      fields_d = fields_t'({hold_q, in_data[7:2]});
      valid_d  = 1'b1;
    end else if (out_xfer) begin
      valid_d  = 1'b0;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q    <= '0;
      hold_q   <= '0;
      fields_q <= '0;
      valid_q  <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      hold_q   <= hold_d;
      fields_q <= fields_d;
      valid_q  <= valid_d;
    end
  end

`ifdef VECTOR3_UNPACKER_CHECK_EN
  logic err_q, err_d;

  // Trailer flag travels with the fields it belongs to.
  always_comb begin
    err_d = err_q;
    if (word_done) begin
      err_d = (in_data[1:0] != 2'b11);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign err = err_q;
`else
  logic unused_trailer;

  // Trailer bits are intentionally dropped in this build.
  assign unused_trailer = ^in_data[1:0];
  assign err            = 1'b0;
`endif

  assign a         = fields_q.a;
  assign b         = fields_q.b;
  assign c         = fields_q.c;
  assign d         = fields_q.d;
  assign e         = fields_q.e;
  assign f         = fields_q.f;
  assign out_valid = valid_q;

endmodule
